// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_rx_state_e;

  // Debug view of the receiver: FSM state, data-bit index and FIFO full flag.
  typedef struct packed {
    uart_rx_state_e state;
    logic [2:0]     bitn;
    logic           fifo_full;
  } uart_rx_dbg_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-facing bus of the UART receiver: byte stream plus status pulses.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake: rx_valid is high while a byte is held and rx_data is stable
  // until it is taken; a transfer (pop) happens on every clock edge where
  // rx_valid && rx_ready. rx_ready may be asserted independently of rx_valid.
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun;
  logic [CW-1:0] fifo_count;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, fifo_count,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, fifo_count,
    output rx_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with explicit occupancy and a drop-on-full pulse.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && !do_push;
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, framing check and a byte FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 54,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rxd,
  uart_rx_fifo_if.master rx_if,
  output uart_rx_dbg_t   dbg
);
  localparam int         TW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [3:0] SMP_MID  = 4'(UART_OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SMP_LAST = 4'(UART_OVERSAMPLE - 1);

  logic           rxd_meta;
  logic           rxd_s;
  logic           rxd_q;
  logic [1:0]     primed;
  logic           fall;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [3:0]     smp;
  logic [2:0]     bitn;
  logic [7:0]     shreg;
  logic           frame_err;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  uart_rx_state_e state;

  // The synchroniser resets high, so its first two outputs are reset residue,
  // not line samples. The edge register holds 0 until real samples arrive,
  // which keeps a line held low across reset from looking like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_q    <= 1'b0;
      primed   <= 2'b00;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      primed   <= {primed[0], 1'b1};
      rxd_q    <= primed[1] ? rxd_s : 1'b0;
    end
  end

  assign fall = rxd_q && !rxd_s;
  assign tick = (tick_cnt == TW'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      smp       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) smp <= smp + 1'b1;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            tick_cnt <= '0;
            smp      <= '0;
            bitn     <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          // Mid start bit: a high line here means a glitch, not a frame.
          if (tick && smp == SMP_MID) begin
            if (!rxd_s) begin
              smp   <= '0;
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick && smp == SMP_LAST) begin
            shreg <= {rxd_s, shreg[7:1]};
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick && smp == SMP_LAST) begin
            frame_err <= !rxd_s;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Push lands on the stop-sample edge so rx_valid rises the cycle after it.
  assign push = (state == ST_STOP) && tick && (smp == SMP_LAST) && rxd_s;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .din     (shreg),
    .pop     (rx_if.rx_ready),
    .dout    (rx_if.rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rx_if.fifo_count),
    .overrun (rx_if.overrun)
  );

  assign rx_if.rx_valid  = !fifo_empty;
  assign rx_if.frame_err = frame_err;

  assign dbg.state     = state;
  assign dbg.bitn      = bitn;
  assign dbg.fifo_full = fifo_full;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side UART front end for the chip's debug console. Sits directly downstream of the `txd` pin of `chip_top`: it deserialises 8N1 frames from the serial line, checks framing, and buffers received bytes in a small FIFO behind a valid/ready interface. It is used in simulation benches to consume console output, and on FPGA builds as the host-side loopback receiver.

## Interface
Parameters:
- `BAUD_DIV`, 54: clock cycles per oversample tick. Bit period = 16 × `BAUD_DIV` cycles. The default gives 115200 baud at 100 MHz.
- `FIFO_DEPTH`, 16: byte entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial line; idle high; asynchronous to `clk`.
- `rx_data`  out  8  head-of-FIFO byte; valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head byte; a pop occurs when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  current occupancy.

## Operation
Input conditioning:
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1.
- An edge-detect register holds the previous synchronised value and resets to 0. A line held low across reset release is therefore not a start edge; the line must go high, then low.

Tick generator:
- Counter runs 0..`BAUD_DIV`-1. A tick is asserted in the cycle the counter equals `BAUD_DIV`-1.
- The counter is cleared to 0 in the start-detect cycle.
- `smp` is a 4-bit tick counter. `bitn` is a 3-bit data-bit index.

FSM states: IDLE, START, DATA, STOP.
- IDLE: on a synchronised falling edge, clear the tick counter, `smp` and `bitn`, then go to START.
- START: on tick 8 (`smp` wraps 7→8), sample the line.
  - Low: go to DATA and clear `smp`.
  - High: false start; return to IDLE with no output.
- DATA: every 16th tick, shift the sampled bit into an 8-bit shift register, LSB first. After bit 7, go to STOP.
- STOP: at the 16th tick, sample the line.
  - High: push the byte.
  - Low: pulse `frame_err` and discard the byte.
  - In both cases, return to IDLE.
- After a framing error, a new start requires a fresh high→low transition.

FIFO:
- Show-ahead: `rx_data` always equals the head entry.
- Push and pop in the same cycle are both honoured.
  - When full, the pop frees a slot and the push is accepted; `overrun` stays low.
  - When empty, a pop is impossible (`rx_valid` = 0), so the push is simply accepted.
- Push when full without a pop: the byte is dropped, `overrun` pulses, and contents are unchanged.
- Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. `fifo_count` is tracked explicitly and saturates at neither end.

## Timing
Reset values:
- `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `fifo_count` = 0.
- FSM in IDLE, pointers 0, shift register 0.

Reset mid-frame discards the partial byte and all FIFO contents.

Latency:
- The falling edge of `rxd` produces a start detect 2–3 cycles later (synchroniser).
- The stop-bit sample occurs 152 × `BAUD_DIV` cycles after the detect cycle.
- `rx_valid` rises, or `frame_err`/`overrun` pulses, in the cycle after that sample.
- After a pop, `rx_valid`, `rx_data` and `fifo_count` update in the following cycle.
- Back-to-back frames: a start edge arriving during STOP, before the stop sample, is ignored. An edge arriving at or after the return to IDLE is detected.

## Structure
- `uart_pkg`: the FSM state enum `uart_rx_state_e` and the constant `UART_OVERSAMPLE` = 16.
- One sub-module, `uart_sync_fifo`, parameterised on width and depth, with push/pop/full/empty/count.
- All other logic (synchroniser, tick generator, FSM) lives in `uart_rx_fifo`.

## Test plan
Unless stated otherwise, benches use `BAUD_DIV` = 4 (64 cycles per bit).
- **Single byte:** send 0xA5 as 8N1 with `rx_ready` = 1.
  - `rx_valid` pulses one cycle with `rx_data` = 0xA5, 152×4+1 cycles after the detect cycle.
  - `frame_err` and `overrun` stay 0.
- **Glitch rejection:** drive `rxd` low for 20 cycles, then high.
  - FSM returns to IDLE; no push; `fifo_count` stays 0.
- **Framing error:** send 0x3C with the stop bit low.
  - `frame_err` pulses exactly once; `fifo_count` stays 0.
  - A following valid 0x11 frame is received correctly.
- **Fill and overrun:** with `rx_ready` = 0, send 17 bytes 0x00..0x10.
  - `fifo_count` reaches 16 and `overrun` pulses once, on the 17th byte.
  - Draining yields 0x00..0x0F in order.
- **Full, push and pop together:** with the FIFO full, assert `rx_ready` in the exact push cycle.
  - No `overrun`; `fifo_count` stays 16.
  - The last entry is the new byte.
- **Reset mid-frame:** assert `rstn` = 0 during bit 4 of a frame, then release with `rxd` low.
  - All outputs return to reset values.
  - No byte is received until `rxd` goes high and a new frame is sent.
